// File: rtl/rvv_pkg.sv
// Shared RVV definitions: register width, LMUL/SEW encodings and the
// writeback sequencer state codes, plus small decode helpers.
package rvv_pkg;

  localparam int VLEN = 64;

  // Largest legal LMUL (x8) and SEW (64-bit) encodings
  localparam logic [2:0] LMUL_MAX = 3'b011;
  localparam logic [2:0] SEW_MAX  = 3'b011;

  typedef logic [1:0] vwb_state_t;
  localparam vwb_state_t ST_IDLE  = 2'd0;
  localparam vwb_state_t ST_WRITE = 2'd1;
  localparam vwb_state_t ST_DONE  = 2'd2;

  function automatic logic [3:0] lmul_regs(input logic [2:0] enc);
    return 4'd1 << enc[1:0];
  endfunction

  function automatic logic [3:0] sew_epr(input logic [2:0] enc);
    return 4'd8 >> enc[1:0];
  endfunction

endpackage

// File: rtl/vwb_tail_mask.sv
// Byte mask for the final beat of a group: covers the bytes occupied by
// the remaining tail elements, saturating to a full register.
module vwb_tail_mask #(
  parameter int VL_W = 8
) (
  input  logic [2:0]      sew_enc,
  input  logic [VL_W-1:0] tail_elems,
  output logic [7:0]      mask
);

  localparam int TBW = VL_W + 3;

  logic [TBW-1:0] tail_bytes;

  always_comb begin
    tail_bytes = {3'b000, tail_elems} << sew_enc;
    mask       = 8'hFF;
    if (tail_bytes < TBW'(8)) mask = ~(8'hFF << tail_bytes[2:0]);
  end

endmodule

// File: rtl/vwb_sequencer.sv
// Grouped vector writeback sequencer: streams ALU result beats into consecutive
// registers of an LMUL group. Final-beat tail masking enabled by VWB_TAIL_MASK_EN.
module vwb_sequencer
  import rvv_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int VL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] wa_base,
  input  logic [2:0]        lmul_enc,
  input  logic [2:0]        sew_enc,
  input  logic [VL_W-1:0]   vl,
  input  logic              res_valid,
  input  logic [VLEN-1:0]   res_data,
  output logic              res_ready,
  output logic              wen,
  output logic [ADDR_W-1:0] wa,
  output logic [VLEN-1:0]   wd,
  output logic [7:0]        wmask,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SW = VL_W + 1;

  vwb_state_t        state;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        nregs_q;
  logic [2:0]        cnt;

  logic [3:0]        epr;
  logic [3:0]        max_regs;
  logic [SW-1:0]     vl_sum;
  logic [SW-1:0]     ceil_regs;
  logic [3:0]        nregs;
  logic [6:0]        tail_start;
  logic [VL_W-1:0]   tail_elems;
  logic              illegal;
  logic              accept;
  logic              last_beat;
  logic [7:0]        beat_mask;

  // Group geometry decoded straight from the start-cycle inputs
  always_comb begin
    epr        = sew_epr(sew_enc);
    max_regs   = lmul_regs(lmul_enc);
    vl_sum     = {1'b0, vl} + SW'(epr) - SW'(1);
    ceil_regs  = vl_sum >> (2'd3 - sew_enc[1:0]);
    nregs      = (ceil_regs > SW'(max_regs)) ? max_regs : ceil_regs[3:0];
    tail_start = 7'(nregs - 4'd1) << (2'd3 - sew_enc[1:0]);
    tail_elems = vl - VL_W'(tail_start);
    illegal    = (lmul_enc > LMUL_MAX) || (sew_enc > SEW_MAX) ||
                 ((wa_base & ADDR_W'(max_regs - 4'd1)) != '0);
  end

  assign res_ready = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign accept    = res_valid && res_ready;
  assign last_beat = ({1'b0, cnt} == (nregs_q - 4'd1));

`ifdef VWB_TAIL_MASK_EN
  logic [2:0]      sew_q;
  logic [VL_W-1:0] tail_q;
  logic [7:0]      tail_mask;

  vwb_tail_mask #(.VL_W(VL_W)) u_tail_mask (
    .sew_enc    (sew_q),
    .tail_elems (tail_q),
    .mask       (tail_mask)
  );

  assign beat_mask = last_beat ? tail_mask : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      sew_q  <= '0;
      tail_q <= '0;
    end else if (state == ST_IDLE && start) begin
      sew_q  <= sew_enc;
      tail_q <= tail_elems;
    end
  end
`else
  assign beat_mask = 8'hFF;
`endif

  // Illegal starts only pulse err; vl=0 goes straight to DONE without writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      base_q  <= '0;
      nregs_q <= '0;
      cnt     <= '0;
      wen     <= 1'b0;
      wa      <= '0;
      wd      <= '0;
      wmask   <= '0;
      err     <= 1'b0;
    end else begin
      wen <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              base_q  <= wa_base;
              nregs_q <= nregs;
              cnt     <= '0;
              state   <= (nregs == 4'd0) ? ST_DONE : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (accept) begin
            wen   <= 1'b1;
            wa    <= base_q + ADDR_W'(cnt);
            wd    <= res_data;
            wmask <= beat_mask;
            cnt   <= cnt + 3'd1;
            if (last_beat) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vwb_sequencer.sv
// Self-checking bench for vwb_sequencer: directed scenarios plus randomized
// operations checked against a per-cycle behavioural model of group writeback.
module tb_vwb_sequencer;

  localparam int ADDR_W = 5;
  localparam int VL_W   = 8;
  localparam int MAXC   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] wa_base;
  logic [2:0]        lmul_enc;
  logic [2:0]        sew_enc;
  logic [VL_W-1:0]   vl;
  logic              res_valid;
  logic [63:0]       res_data;
  logic              res_ready;
  logic              wen;
  logic [ADDR_W-1:0] wa;
  logic [63:0]       wd;
  logic [7:0]        wmask;
  logic              busy;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vwb_sequencer #(.ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .wa_base(wa_base),
    .lmul_enc(lmul_enc), .sew_enc(sew_enc), .vl(vl),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .wen(wen), .wa(wa), .wd(wd), .wmask(wmask),
    .busy(busy), .done(done), .err(err)
  );

  logic [ADDR_W-1:0] obs_wa[$];
  logic [63:0]       obs_wd[$];
  logic [7:0]        obs_mask[$];
  int                obs_wcyc[$];
  int obs_done_n, obs_done_cyc, obs_err_n, obs_err_cyc, obs_busy_n, obs_ready_n;
  bit obs_done_wen;

  logic [ADDR_W-1:0] exp_wa[$];
  logic [63:0]       exp_wd[$];
  logic [7:0]        exp_mask[$];
  int                exp_wcyc[$];
  int exp_done_cyc, exp_busy_n, exp_ready_n;
  bit exp_illegal, exp_done_wen;

  logic [63:0] sent_data[MAXC];
  bit          sent_valid[MAXC];

  function automatic bit model_illegal(int b, int lm, int sw);
    if (lm > 3 || sw > 3) return 1'b1;
    return (b % (1 << lm)) != 0;
  endfunction

  function automatic int model_nregs(int lm, int sw, int v);
    int epr = 8 / (1 << sw);
    int n = 0;
    int left = v;
    while (left > 0 && n < (1 << lm)) begin
      n++;
      left -= epr;
    end
    return n;
  endfunction

  // Bytes of register `beat` holding active elements; full when tail-agnostic
  function automatic logic [7:0] model_mask(int sw, int v, int beat);
    int esize = 1 << sw;
    int epr = 8 / esize;
    int elems = v - beat * epr;
    int bytes;
    logic [7:0] m;
    if (elems > epr) elems = epr;
    bytes = elems * esize;
    m = (bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
`ifndef VWB_TAIL_MASK_EN
    m = 8'hFF;
`endif
    return m;
  endfunction

  task automatic build_expected(input int b, input int lm, input int sw, input int v);
    int n, beat, last;
    exp_wa.delete(); exp_wd.delete(); exp_mask.delete(); exp_wcyc.delete();
    exp_illegal = model_illegal(b, lm, sw);
    exp_done_wen = 1'b0;
    if (exp_illegal) begin
      exp_done_cyc = -1; exp_busy_n = 0; exp_ready_n = 0;
      return;
    end
    n = model_nregs(lm, sw, v);
    beat = 0;
    last = 0;
    for (int c = 1; c < MAXC && beat < n; c++) begin
      if (sent_valid[c]) begin
        exp_wa.push_back(ADDR_W'(b + beat));
        exp_wd.push_back(sent_data[c]);
        exp_mask.push_back(model_mask(sw, v, beat));
        exp_wcyc.push_back(c + 1);
        last = c;
        beat++;
      end
    end
    exp_done_cyc = (n == 0) ? 1 : last + 1;
    exp_done_wen = (n != 0);
    exp_busy_n   = exp_done_cyc;
    exp_ready_n  = (n == 0) ? 0 : last;
  endtask

  // Launches one operation at cycle 0 and records what the DUT does per cycle
  task automatic run_op(input int b, input int lm, input int sw, input int v,
                        input logic [31:0] vpat, input bit rnd, input bit spam);
    int stop;
    obs_wa.delete(); obs_wd.delete(); obs_mask.delete(); obs_wcyc.delete();
    obs_done_n = 0; obs_done_cyc = -1; obs_err_n = 0; obs_err_cyc = -1;
    obs_busy_n = 0; obs_ready_n = 0; obs_done_wen = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      sent_valid[i] = 1'b0;
      sent_data[i]  = '0;
    end
    wa_base = ADDR_W'(b); lmul_enc = 3'(lm); sew_enc = 3'(sw); vl = VL_W'(v);
    start = 1'b1;
    res_valid = 1'b0;
    stop = MAXC - 1;
    for (int c = 1; c <= stop; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wen) begin
        obs_wa.push_back(wa); obs_wd.push_back(wd);
        obs_mask.push_back(wmask); obs_wcyc.push_back(c);
      end
      if (done) begin
        obs_done_n++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c;
          obs_done_wen = wen;
        end
        if (stop > c + 2) stop = c + 2;
      end
      if (err) begin
        obs_err_n++;
        if (obs_err_cyc < 0) obs_err_cyc = c;
        if (stop > c + 2) stop = c + 2;
      end
      if (busy) obs_busy_n++;
      if (res_ready) obs_ready_n++;
      sent_valid[c] = rnd ? bit'($urandom_range(0, 1)) : vpat[c % 32];
      sent_data[c]  = {$urandom, $urandom};
      res_valid = sent_valid[c];
      res_data  = sent_data[c];
      if (spam && busy) begin
        start = 1'b1;
        wa_base = ADDR_W'($urandom_range(0, 31));
        lmul_enc = 3'($urandom_range(0, 3));
        vl = VL_W'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; res_valid = 1'b0; res_data = '0;
    wa_base = '0; lmul_enc = '0; sew_enc = '0; vl = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({wen, busy, done, err, res_ready} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got wen/busy/done/err/ready=%b want 00000",
               {wen, busy, done, err, res_ready});
    end
    vectors++;
    if ({wa, wmask} !== '0 || wd !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got wa=%0d wd=%h wmask=%h want all zero", wa, wd, wmask);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || res_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got busy=%b ready=%b want 0 0", busy, res_ready);
    end
  endtask

  task automatic test_single_beat;
    run_op(4, 0, 0, 8, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vectors++;
    if (obs_wa.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d writes want 1", obs_wa.size());
    end else begin
      vectors++;
      if (obs_wa[0] !== 5'd4 || obs_mask[0] !== 8'hFF || obs_wd[0] !== sent_data[1]) begin
        miscompares++;
        $display("[TB] FAIL single_write: got wa=%0d wmask=%h wd=%h want wa=4 wmask=ff wd=%h",
                 obs_wa[0], obs_mask[0], obs_wd[0], sent_data[1]);
      end
    end
    vectors++;
    if (obs_done_cyc != 2 || obs_done_wen !== 1'b1 || obs_done_n != 1) begin
      miscompares++;
      $display("[TB] FAIL single_done: got cycle=%0d with_wen=%b pulses=%0d want 2 1 1",
               obs_done_cyc, obs_done_wen, obs_done_n);
    end
  endtask

  task automatic test_group;
    logic [7:0] want_last;
`ifdef VWB_TAIL_MASK_EN
    want_last = 8'h0F;
`else
    want_last = 8'hFF;
`endif
    run_op(8, 2, 2, 7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vectors++;
    if (obs_wa.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL group_count: got %0d writes want 4", obs_wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs_wa[i] !== ADDR_W'(8 + i) || obs_mask[i] !== ((i == 3) ? want_last : 8'hFF)) begin
          miscompares++;
          $display("[TB] FAIL group_beat%0d: got wa=%0d wmask=%h want wa=%0d wmask=%h", i,
                   obs_wa[i], obs_mask[i], 8 + i, (i == 3) ? want_last : 8'hFF);
        end
      end
    end
    vectors++;
    if (obs_done_cyc != 5 || obs_busy_n != 5) begin
      miscompares++;
      $display("[TB] FAIL group_done: got done_cycle=%0d busy_cycles=%0d want 5 5",
               obs_done_cyc, obs_busy_n);
    end
  endtask

  task automatic test_vl_zero;
    run_op(2, 1, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vectors++;
    if (obs_wa.size() != 0 || obs_done_cyc != 1 || obs_done_n != 1 || obs_busy_n != 1 ||
        obs_ready_n != 0) begin
      miscompares++;
      $display("[TB] FAIL vl_zero: got writes=%0d done_cycle=%0d pulses=%0d busy=%0d ready=%0d want 0 1 1 1 0",
               obs_wa.size(), obs_done_cyc, obs_done_n, obs_busy_n, obs_ready_n);
    end
  endtask

  task automatic test_backpressure;
    run_op(6, 1, 0, 16, 32'h0000_0012, 1'b0, 1'b0);
    vectors++;
    if (obs_wa.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d writes want 2", obs_wa.size());
    end else begin
      vectors++;
      if (obs_wa[0] !== 5'd6 || obs_wa[1] !== 5'd7 || obs_wcyc[0] != 2 || obs_wcyc[1] != 5 ||
          obs_wd[0] !== sent_data[1] || obs_wd[1] !== sent_data[4]) begin
        miscompares++;
        $display("[TB] FAIL bp_writes: got wa=%0d,%0d at cycles %0d,%0d want 6,7 at 2,5",
                 obs_wa[0], obs_wa[1], obs_wcyc[0], obs_wcyc[1]);
      end
    end
    vectors++;
    if (obs_done_cyc != 5 || obs_done_wen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_done: got cycle=%0d with_wen=%b want 5 1", obs_done_cyc, obs_done_wen);
    end
  endtask

  task automatic test_illegal;
    int cfg[2][3] = '{'{5, 1, 0}, '{4, 0, 4}};
    for (int k = 0; k < 2; k++) begin
      run_op(cfg[k][0], cfg[k][1], cfg[k][2], 4, 32'hFFFF_FFFF, 1'b0, 1'b0);
      vectors++;
      if (obs_err_n != 1 || obs_err_cyc != 1 || obs_wa.size() != 0 || obs_busy_n != 0 ||
          obs_done_n != 0) begin
        miscompares++;
        $display("[TB] FAIL illegal%0d: got err=%0d at %0d writes=%0d busy=%0d done=%0d want 1 at 1, 0 0 0",
                 k, obs_err_n, obs_err_cyc, obs_wa.size(), obs_busy_n, obs_done_n);
      end
    end
  endtask

  task automatic test_reset_mid;
    int late_wen = 0;
    wa_base = 5'd12; lmul_enc = 3'd2; sew_enc = 3'd0; vl = 8'd32;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_valid = 1'b1;
    res_data = {$urandom, $urandom};
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    res_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || wen !== 1'b0 || res_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: got busy=%b wen=%b ready=%b want 0 0 0", busy, wen, res_ready);
    end
    rst = 1'b0;
    res_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (wen) late_wen++;
    end
    res_valid = 1'b0;
    vectors++;
    if (late_wen != 0) begin
      miscompares++;
      $display("[TB] FAIL midrst_wen: got %0d writes after reset want 0", late_wen);
    end
    run_op(3, 0, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vectors++;
    if (obs_wa.size() != 1 || obs_done_cyc != 2) begin
      miscompares++;
      $display("[TB] FAIL midrst_restart: got writes=%0d done_cycle=%0d want 1 2", obs_wa.size(), obs_done_cyc);
    end else begin
      vectors++;
      if (obs_wa[0] !== 5'd3 || obs_mask[0] !== model_mask(0, 1, 0)) begin
        miscompares++;
        $display("[TB] FAIL midrst_write: got wa=%0d wmask=%h want 3 %h", obs_wa[0], obs_mask[0],
                 model_mask(0, 1, 0));
      end
    end
  endtask

  task automatic test_random;
    int b, lm, sw, v;
    bit spam;
    for (int t = 0; t < 40; t++) begin
      lm = $urandom_range(0, 4);
      sw = $urandom_range(0, 4);
      v = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 70);
      b = $urandom_range(0, 31);
      if ($urandom_range(0, 4) != 0 && lm <= 3) b = b & ~((1 << lm) - 1);
      spam = bit'($urandom_range(0, 1));
      run_op(b, lm, sw, v, 32'h0, 1'b1, spam);
      build_expected(b, lm, sw, v);
      vectors++;
      if (obs_wa.size() != exp_wa.size()) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_count: got %0d writes want %0d (base=%0d lmul=%0d sew=%0d vl=%0d)",
                 t, obs_wa.size(), exp_wa.size(), b, lm, sw, v);
      end else begin
        foreach (exp_wa[i]) begin
          vectors++;
          if (obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i] || obs_mask[i] !== exp_mask[i] ||
              obs_wcyc[i] != exp_wcyc[i]) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_beat%0d: got wa=%0d wd=%h wmask=%h cyc=%0d want wa=%0d wd=%h wmask=%h cyc=%0d",
                     t, i, obs_wa[i], obs_wd[i], obs_mask[i], obs_wcyc[i],
                     exp_wa[i], exp_wd[i], exp_mask[i], exp_wcyc[i]);
          end
        end
      end
      vectors++;
      if (obs_done_cyc != exp_done_cyc || obs_done_n != (exp_illegal ? 0 : 1) ||
          obs_done_wen != exp_done_wen || obs_err_n != (exp_illegal ? 1 : 0) ||
          obs_busy_n != exp_busy_n || obs_ready_n != exp_ready_n) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_ctrl: got done=%0d/%0d/%b err=%0d busy=%0d ready=%0d want done=%0d/%0d/%b err=%0d busy=%0d ready=%0d",
                 t, obs_done_cyc, obs_done_n, obs_done_wen, obs_err_n, obs_busy_n, obs_ready_n,
                 exp_done_cyc, exp_illegal ? 0 : 1, exp_done_wen, exp_illegal ? 1 : 0,
                 exp_busy_n, exp_ready_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_group();
    test_vl_zero();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vwb_sequencer.md
VWB_SEQUENCER -- requirements
Module: vwb_sequencer

Interface
- REQ-001 SHALL have parameter ADDR_W, default 5: vector register address width.
- REQ-002 SHALL have parameter VL_W, default 8: vl width.
- REQ-003 SHALL have port `clk`, input, 1 bit: single clock; all state changes on rising edge.
- REQ-004 SHALL have port `rst`, input, 1 bit: reset, synchronous, active-high.
- REQ-005 SHALL have port `start`, input, 1 bit: one-cycle pulse launching a grouped writeback.
- REQ-006 SHALL have port `wa_base`, input, ADDR_W bits: group base destination register.
- REQ-007 SHALL have port `lmul_enc`, input, 3 bits: 000=1, 001=2, 010=4, 011=8 registers; other codes invalid.
- REQ-008 SHALL have port `sew_enc`, input, 3 bits: 000=8, 001=16, 010=32, 011=64 bits; other codes invalid.
- REQ-009 SHALL have port `vl`, input, VL_W bits: active element count.
- REQ-010 SHALL have port `res_valid`, input, 1 bit: ALU result beat valid.
- REQ-011 SHALL have port `res_data`, input, 64 bits: one register-wide result beat.
- REQ-012 SHALL have port `res_ready`, output, 1 bit: sequencer accepts a beat.
- REQ-013 SHALL have port `wen`, output, 1 bit: register file write enable.
- REQ-014 SHALL have port `wa`, output, ADDR_W bits: register file write address.
- REQ-015 SHALL have port `wd`, output, 64 bits: register file write data.
- REQ-016 SHALL have port `wmask`, output, 8 bits: byte write mask.
- REQ-017 SHALL have port `busy`, output, 1 bit: operation in progress.
- REQ-018 SHALL have port `done`, output, 1 bit: one-cycle completion pulse.
- REQ-019 SHALL have port `err`, output, 1 bit: one-cycle illegal-configuration pulse.

Function
- REQ-020 SHALL implement FSM states IDLE, WRITE, DONE.
- REQ-021 SHALL, in IDLE on `start`, latch `wa_base`, `lmul_enc`, `sew_enc` and `vl`, then enter WRITE.
- REQ-022 SHALL ignore `start` outside IDLE.
- REQ-023 SHALL compute epr = 8 >> sew_enc and nregs = min(ceil(vl/epr), 1 << lmul_enc), using a 9-bit intermediate for vl+epr-1.
- REQ-024 SHALL assert `res_ready` only in WRITE; a beat transfers when `res_valid` and `res_ready` are both high.
- REQ-025 SHALL, for an accept in cycle N, drive `wen`=1, `wa`=latched base+cnt, `wd`=beat and `wmask` in cycle N+1 (registered outputs); `wen`=0 otherwise.
- REQ-026 SHALL keep a 3-bit beat counter cnt that starts at 0, increments per accept, and moves the FSM to DONE on the accept with cnt=nregs-1.
- REQ-027 SHALL assert `done` for exactly one cycle, coincident with the final `wen`; DONE then returns to IDLE.
- REQ-028 SHALL, for vl=0 with a legal configuration, make no writes and assert `done` in the cycle after `start`.
- REQ-029 SHALL treat invalid lmul_enc or sew_enc, or wa_base not aligned to 1<<lmul_enc, as illegal: `err` pulses in the cycle after `start`, no `wen`, no `done`, FSM stays IDLE.
- REQ-030 SHALL drive `busy`=1 from the cycle after an accepted `start` through the `done` cycle inclusive.
- REQ-031 SHALL, when vl > nregs*epr, clamp the writes to nregs beats with a full mask on every beat.

Reset
- REQ-032 SHALL, while `rst`=1 at a clock edge, force IDLE, cnt=0, `wen`=0, `wa`=0, `wd`=0, `wmask`=0, `busy`=0, `done`=0, `err`=0 and `res_ready`=0.
- REQ-033 SHALL abort any operation in progress on reset mid-operation: no further `wen`, and the next `start` after reset SHALL behave normally.

Configuration
- REQ-034 SHALL, with macro VWB_TAIL_MASK_EN defined, set `wmask`=8'hFF on non-final beats; on the final beat it SHALL set the low (tail_elems << sew_enc) bits, where tail_elems = vl - (nregs-1)*epr; 8 bytes SHALL give 8'hFF.
- REQ-035 SHALL, without VWB_TAIL_MASK_EN, drive `wmask`=8'hFF on every write (tail-agnostic).

Structure
- REQ-036 SHALL take the FSM state enum, the LMUL/SEW encoding constants and VLEN=64 from shared package rvv_pkg.
- REQ-037 SHALL place tail-mask generation in sub-module vwb_tail_mask (inputs sew_enc and tail_elems; output 8-bit mask), instantiated only under VWB_TAIL_MASK_EN.

Verification
- REQ-038 SHALL verify: lmul=000, sew=000, vl=8, base=4, one beat -> next cycle wen=1, wa=4, wmask=FF, done=1.
- REQ-039 SHALL verify: lmul=010, sew=010, vl=7, base=8, four beats -> writes to wa=8,9,10,11; last wmask=0F with the macro, FF without.
- REQ-040 SHALL verify: vl=0, lmul=001, base=2 -> done one cycle after start, no wen.
- REQ-041 SHALL verify backpressure: lmul=001, vl=16, sew=000, res_valid toggled 1,0,0,1 -> exactly two writes (wa=base, base+1), done on the second.
- REQ-042 SHALL verify illegal configuration: lmul=001, base=5 and separately sew=100 -> err pulse, no wen, busy stays 0.
- REQ-043 SHALL verify reset mid-operation: rst after 2 of 4 beats -> busy=0, wen=0, and a new start for lmul=000, vl=1 completes with wa=base, wmask=01 (macro on).
